// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier datapath.
// Holds the controller state encoding and the default operand width.
package mult_pkg;

  localparam int MULT_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mult_state_t;

endpackage : mult_pkg

// File: rtl/full_adder.sv
// Single-bit full adder cell, the building block of the ripple-carry chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule : full_adder

// File: rtl/ripple_carry_adder.sv
// WIDTH-bit ripple-carry adder built from a series chain of full_adder cells.
module ripple_carry_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    full_adder u_fa (
      .a    (A[i]),
      .b    (B[i]),
      .cin  (carry[i]),
      .sum  (S[i]),
      .cout (carry[i+1])
    );
  end

  assign Cout = carry[WIDTH];

endmodule : ripple_carry_adder

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier with a start/done handshake.
// One add-and-shift iteration per cycle through a ripple_carry_adder.
//
// state   | meaning
// IDLE    | waiting for start; operands loaded on accept
// RUN     | one add-and-shift iteration per cycle, WIDTH iterations
// DONE    | product valid on P, done pulses for one cycle
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] P
);

  localparam int CW = $clog2(WIDTH) + 1;

  mult_state_t state, next_state;

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic [2*WIDTH-1:0] shifted;
  logic               last_iter;

  assign addend    = acc_lo[0] ? mcand : '0;
  assign last_iter = (cnt == CW'(WIDTH - 1));

  ripple_carry_adder #(
    .WIDTH (WIDTH)
  ) u_rca (
    .A    (acc_hi),
    .B    (addend),
    .Cin  (1'b0),
    .S    (sum),
    .Cout (cout)
  );

  // The adder carry becomes the new MSB of acc_hi, so nothing is lost.
  assign shifted = {cout, sum, acc_lo[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last_iter) begin
          next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
      P      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mcand  <= A;
            acc_hi <= '0;
            acc_lo <= B;
            cnt    <= '0;
          end
        end
        ST_RUN: begin
          {acc_hi, acc_lo} <= shifted;
          cnt              <= cnt + CW'(1);
          if (last_iter) begin
            P <= shifted;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule : shift_add_multiplier
